// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch stage.
//   NOP_INST         - word injected into IF/ID when the wrong-path fetch is flushed
//   WORD_BYTES       - instruction size in bytes (PC stride)
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   ALIGN_MASK       - clears the byte offset of a redirect target
package cpu_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = ~(32'(WORD_BYTES) - 32'd1);

endpackage

// File: rtl/pc_register.sv
// pc_register: 32-bit program counter with load enable and synchronous reset.
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset, loads RESET_VAL
//   i_load_en - load i_next_pc on this edge
//   i_next_pc - next PC value
//   o_pc      - current PC (straight from the register)
module pc_register #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load_en,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VAL;
    end else if (i_load_en) begin
      r_pc <= i_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with next-PC selection and the IF/ID pipeline register.
//   clk, rst                   - clock and synchronous active-high reset
//   stall                      - hold PC and IF/ID (ignored when a redirect is present)
//   branch_taken/branch_target - redirect, lower priority than jump
//   jump/jump_target           - redirect, highest priority after reset
//   inst_addr                  - PC, drives instruction memory address
//   inst_in                    - memory word for inst_addr (combinational memory)
//   if_id_inst/pc4/valid       - registered instruction, its PC+4 and valid flag
// Optional feature (macro FETCH_PERF_CNT_EN): fetch_count and flush_count outputs.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_pc_load;

  logic [31:0] r_if_id_inst;
  logic [31:0] r_if_id_pc4;
  logic        r_if_id_valid;

  assign w_redirect = jump | branch_taken;
  assign w_pc4      = w_pc + 32'(WORD_BYTES);
  // A redirect overrides stall: the wrong-path word is discarded anyway.
  assign w_pc_load  = w_redirect | ~stall;

  always_comb begin
    w_next_pc = w_pc4;
    if (jump) begin
      w_next_pc = jump_target & ALIGN_MASK;
    end else if (branch_taken) begin
      w_next_pc = branch_target & ALIGN_MASK;
    end
  end

  pc_register #(
    .RESET_VAL (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .i_load_en (w_pc_load),
    .i_next_pc (w_next_pc),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_id_inst  <= NOP_INST;
      r_if_id_pc4   <= 32'h0;
      r_if_id_valid <= 1'b0;
    end else if (w_redirect) begin
      r_if_id_inst  <= NOP_INST;
      r_if_id_pc4   <= 32'h0;
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      r_if_id_inst  <= inst_in;
      r_if_id_pc4   <= w_pc4;
      r_if_id_valid <= 1'b1;
    end
  end

  assign inst_addr   = w_pc;
  assign if_id_inst  = r_if_id_inst;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'h0;
      r_flush_count <= 32'h0;
    end else if (w_redirect) begin
      r_flush_count <= r_flush_count + 32'd1;
    end else if (!stall) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized traffic for instruction_fetch,
// checked against a behavioural model of the fetch stage. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers PC wrap-around. Counters are checked when
// FETCH_PERF_CNT_EN is defined.
module tb_instruction_fetch;

  localparam logic [31:0] LW_WORD  = 32'h0000_2083;
  localparam logic [31:0] ADD_WORD = 32'h0020_8133;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  // Wrap-around instance
  logic        rst_w;
  logic        zero_1;
  logic [31:0] zero_32;
  logic [31:0] addr_w;
  logic [31:0] inst_in_w;
  logic [31:0] inst_w;
  logic [31:0] pc4_w;
  logic        valid_w;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fc_w;
  logic [31:0] flc_w;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model state
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_fc;
  logic [31:0] m_flc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return LW_WORD;
    if (a == 32'h4) return ADD_WORD;
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  assign inst_in   = mem_word(inst_addr);
  assign inst_in_w = mem_word(addr_w);
  assign zero_1    = 1'b0;
  assign zero_32   = 32'h0;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .inst_addr     (inst_addr),
    .inst_in       (inst_in),
    .if_id_inst    (if_id_inst),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .flush_count   (flush_count)
`endif
  );

  instruction_fetch #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk           (clk),
    .rst           (rst_w),
    .stall         (zero_1),
    .branch_taken  (zero_1),
    .branch_target (zero_32),
    .jump          (zero_1),
    .jump_target   (zero_32),
    .inst_addr     (addr_w),
    .inst_in       (inst_in_w),
    .if_id_inst    (inst_w),
    .if_id_pc4     (pc4_w),
    .if_id_valid   (valid_w)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fc_w),
    .flush_count   (flc_w)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Fetch-stage behaviour from the priority rules: rst > jump > branch > stall > PC+4.
  task automatic model_edge(input logic r, input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt);
    if (r) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_fc = 32'h0; m_flc = 32'h0;
    end else if (j || b) begin
      m_pc = (j ? jt : bt);
      m_pc[1:0] = 2'b00;
      m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_flc = m_flc + 1;
    end else if (!s) begin
      m_inst = mem_word(m_pc);
      m_pc   = m_pc + 4;
      m_pc4  = m_pc;
      m_valid = 1'b1;
      m_fc = m_fc + 1;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".inst_addr"}, inst_addr, m_pc);
    check_eq({tag, ".if_id_inst"}, if_id_inst, m_inst);
    check_eq({tag, ".if_id_pc4"}, if_id_pc4, m_pc4);
    check_eq({tag, ".if_id_valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    check_eq({tag, ".fetch_count"}, fetch_count, m_fc);
    check_eq({tag, ".flush_count"}, flush_count, m_flc);
`endif
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic b,
                      input logic [31:0] bt, input logic j, input logic [31:0] jt);
    @(negedge clk);
    rst = r; stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    model_edge(r, s, b, bt, j, jt);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; rst_w = 1'b1;
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fc = 32'h0; m_flc = 32'h0;

    step("reset", 1, 0, 0, 0, 0, 0);
    check_eq("wrap.reset_pc", addr_w, 32'hFFFF_FFFC);
    check_eq("wrap.reset_valid", {31'h0, valid_w}, 32'h0);
    rst_w = 1'b0;
    check_eq("reset.pc_abs", inst_addr, 32'h0);

    step("run1", 0, 0, 0, 0, 0, 0);
    check_eq("wrap.pc_wrapped", addr_w, 32'h0000_0000);
    check_eq("wrap.pc4_wrapped", pc4_w, 32'h0000_0000);
    check_eq("wrap.inst", inst_w, mem_word(32'hFFFF_FFFC));
    check_eq("run1.lw_abs", if_id_inst, LW_WORD);
    step("run2", 0, 0, 0, 0, 0, 0);
    check_eq("run2.add_abs", if_id_inst, ADD_WORD);
    check_eq("run2.pc_abs", inst_addr, 32'h8);

    // Input changes between edges must not reach inst_addr.
    jump = 1'b1; jump_target = 32'h0000_0F00; branch_taken = 1'b1; stall = 1'b1;
    #1;
    check_eq("no_comb_path", inst_addr, 32'h8);

    step("stall1", 0, 1, 0, 0, 0, 0);
    step("stall2", 0, 1, 0, 0, 0, 0);
    check_eq("stall.pc_abs", inst_addr, 32'h8);
    step("resume", 0, 0, 0, 0, 0, 0);
    check_eq("resume.pc_abs", inst_addr, 32'hC);

    step("branch", 0, 0, 1, 32'h0000_0042, 0, 0);
    check_eq("branch.pc_abs", inst_addr, 32'h40);
    step("after_branch", 0, 0, 0, 0, 0, 0);
    check_eq("after_branch.inst_abs", if_id_inst, mem_word(32'h40));

    step("jmp_br_stall", 0, 1, 1, 32'h0000_0200, 1, 32'h0000_0100);
    check_eq("jmp_br_stall.pc_abs", inst_addr, 32'h100);

    step("rst_mid_stall", 1, 1, 1, 32'h0000_0300, 1, 32'h0000_0400);

    // Counter scenario: 5 fetches, 1 branch, then reset.
    for (int i = 0; i < 5; i++) step("cnt_run", 0, 0, 0, 0, 0, 0);
    step("cnt_branch", 0, 0, 1, 32'h0000_0080, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("cnt.fetch5", fetch_count, 32'd5);
    check_eq("cnt.flush1", flush_count, 32'd1);
`endif
    step("cnt_rst", 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(31) == 0), ($urandom_range(3) == 0),
           ($urandom_range(5) == 0), $urandom, ($urandom_range(7) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1, hazard hold request from decode.
REQ-005 The block SHALL have port branch_taken, input, 1, redirect to branch_target.
REQ-006 The block SHALL have port branch_target, input, 32, branch destination byte address.
REQ-007 The block SHALL have port jump, input, 1, redirect to jump_target.
REQ-008 The block SHALL have port jump_target, input, 32, jump destination byte address.
REQ-009 The block SHALL have port inst_addr, output, 32, current PC, driven to the instruction memory addr input.
REQ-010 The block SHALL have port inst_in, input, 32, word returned combinationally by instruction memory for inst_addr.
REQ-011 The block SHALL have port if_id_inst, output, 32, registered instruction for decode.
REQ-012 The block SHALL have port if_id_pc4, output, 32, registered PC+4 of that instruction.
REQ-013 The block SHALL have port if_id_valid, output, 1, high when if_id_inst is a real fetched instruction.

Function
REQ-014 inst_addr SHALL equal the PC register directly (no combinational path from any input).
REQ-015 Next-PC priority SHALL be: rst > jump > branch_taken > stall > PC+4.
REQ-016 Redirect (jump or branch_taken) SHALL take effect even when stall is high.
REQ-017 Redirect targets SHALL be loaded with bits [1:0] forced to 2'b00.
REQ-018 PC+4 SHALL be 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-019 Normal cycle (no redirect, no stall): if_id_inst <= inst_in, if_id_pc4 <= PC+4, if_id_valid <= 1, one-cycle latency.
REQ-020 Stall without redirect: PC and all if_id_* SHALL hold their values.
REQ-021 Redirect cycle: if_id_inst <= NOP_INST (32'h0), if_id_pc4 <= 0, if_id_valid <= 0 (flush of the wrong-path word).
REQ-022 Jump and branch_taken both high SHALL select jump_target.

Reset
REQ-023 On rst: PC <= RESET_PC, if_id_inst <= 32'h0, if_id_pc4 <= 32'h0, if_id_valid <= 0.
REQ-024 rst asserted mid-stall or mid-redirect SHALL override both in the same edge.
REQ-025 First instruction after reset deassertion SHALL appear in if_id_inst one edge later, fetched from RESET_PC.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN, when defined, SHALL add outputs fetch_count[31:0] (increments on each REQ-019 cycle) and flush_count[31:0] (increments on each redirect cycle), both cleared by rst, wrapping modulo 2^32.
REQ-027 Without FETCH_PERF_CNT_EN the counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package cpu_pkg SHALL hold NOP_INST, WORD_BYTES (4) and the default reset PC constant.
REQ-029 A sub-module pc_register (32-bit PC with load-enable and sync reset) SHALL hold the PC; next-PC mux and IF/ID register live in instruction_fetch.

Verification
REQ-030 Reset, then 3 free-running cycles with memory holding LW/ADD words at 0/4 -> inst_addr 0,4,8; if_id_inst = LW word, then ADD word; if_id_pc4 = 4, then 8.
REQ-031 stall high 2 cycles at PC=8 -> inst_addr stays 8, if_id_* unchanged; resumes at 12 after release.
REQ-032 branch_taken with branch_target=32'h0000_0042 -> next inst_addr 32'h40, if_id_valid 0 for one cycle, then valid fetch from 0x40.
REQ-033 jump=1 (target 0x100), branch_taken=1 (target 0x200), stall=1 same cycle -> inst_addr 0x100, flush.
REQ-034 RESET_PC=32'hFFFF_FFFC, run 2 cycles -> inst_addr FFFF_FFFC then 0000_0000.
REQ-035 With FETCH_PERF_CNT_EN: 5 normal cycles + 1 branch + rst -> fetch_count 5, flush_count 1, then both 0.
